// File: rtl/div_pkg.sv
// div_pkg: shared divider types and default datapath width.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/div_abs.sv
// div_abs: conditional two's-complement negate, also reports the operand sign.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             neg
);
  assign neg = is_signed & x[WIDTH-1];
  assign y   = neg ? -x : x;
endmodule

// File: rtl/div_prealign.sv
// div_prealign: iterative divisor alignment, finds largest k with (|b| << k) <= |a|.
module div_prealign
  import div_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] shifted_b,
  output logic [SHW-1:0]   shamt,
  output logic             div_zero,
  output logic             a_lt_b,
  output logic             q_neg,
  output logic             r_neg
);
  state_t           state;
  logic [WIDTH-1:0] ua, ub, bw;
  logic             na, nb, sa, sb;
  logic [SHW-1:0]   cnt;
  logic             accept, zero, lt, fin;
  div_abs #(.WIDTH(WIDTH)) u_abs_a (.is_signed(is_signed), .x(a), .y(ua), .neg(na));
  div_abs #(.WIDTH(WIDTH)) u_abs_b (.is_signed(is_signed), .x(b), .y(ub), .neg(nb));
  assign accept = start && state != SHIFT;
  assign zero   = bw == '0;
  assign lt     = cnt == '0 && bw > abs_a;
  // Doubling is compared at WIDTH+1 bits so the shifted-out MSB is never lost.
  assign fin    = zero || lt || bw[WIDTH-1] || {bw, 1'b0} > {1'b0, abs_a};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      abs_a     <= '0;
      shifted_b <= '0;
      shamt     <= '0;
      div_zero  <= 1'b0;
      a_lt_b    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      bw        <= '0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state     <= SHIFT;
        ready     <= 1'b0;
        abs_a     <= ua;
        bw        <= ub;
        sa        <= na;
        sb        <= nb;
        cnt       <= '0;
        shifted_b <= '0;
        shamt     <= '0;
        div_zero  <= 1'b0;
        a_lt_b    <= 1'b0;
        q_neg     <= 1'b0;
        r_neg     <= 1'b0;
      end else if (state == SHIFT && fin) begin
        state     <= DONE;
        ready     <= 1'b1;
        done      <= 1'b1;
        div_zero  <= zero;
        a_lt_b    <= !zero && lt;
        shamt     <= (zero || lt) ? '0 : cnt;
        shifted_b <= zero ? '0 : bw;
        q_neg     <= !zero && (sa ^ sb);
        r_neg     <= sa;
      end else if (state == SHIFT) begin
        bw  <= bw << 1;
        cnt <= cnt + 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_div_prealign.sv
// tb_div_prealign: directed checks of alignment results, latency, handshake and reset.
module tb_div_prealign;
  logic        clk = 0, rst_n = 0, start = 0, is_signed = 0;
  logic [31:0] a = 0, b = 0;
  logic        ready, done, div_zero, a_lt_b, q_neg, r_neg;
  logic [31:0] abs_a, shifted_b;
  logic [4:0]  shamt;
  logic [72:0] res;
  int          total = 0, bad = 0, cyc;

  div_prealign #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .ready(ready), .done(done), .abs_a(abs_a), .shifted_b(shifted_b), .shamt(shamt),
    .div_zero(div_zero), .a_lt_b(a_lt_b), .q_neg(q_neg), .r_neg(r_neg)
  );

  always #5 clk = ~clk;
  assign res = {abs_a, shifted_b, shamt, div_zero, a_lt_b, q_neg, r_neg};

  // Leaves the bench in cycle 1 (just after the accepting edge).
  task automatic go(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    is_signed = s; a = x; b = y; start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  // c counts negedges from the current cycle; -1 on timeout.
  task automatic wait_done(output int c);
    c = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin c = i; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({ready, done, res} !== {1'b1, 1'b0, 73'd0}) begin
      bad++; $display("FAIL reset got=%h want=%h", {ready, done, res}, {1'b1, 1'b0, 73'd0});
    end
    rst_n = 1;
  endtask

  task automatic run(input string name, input logic s, input logic [31:0] x, input logic [31:0] y,
                     input int want_cyc, input logic [72:0] want);
    go(s, x, y);
    wait_done(cyc);
    total++;
    if (cyc !== want_cyc) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, want_cyc);
    end
    total++;
    if (res !== want) begin
      bad++; $display("FAIL %s_result got=%h want=%h", name, res, want);
    end
  endtask

  task automatic test_hold;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, done, res} !== {1'b1, 1'b0, 32'd100, 32'd56, 5'd3, 4'b0000}) begin
      bad++; $display("FAIL hold got=%h want=%h", {ready, done, res},
                      {1'b1, 1'b0, 32'd100, 32'd56, 5'd3, 4'b0000});
    end
  endtask

  task automatic test_start_in_shift;
    go(0, 100, 7);
    @(negedge clk);
    start = 1; a = 5; b = 9;
    @(posedge clk);
    #1 start = 0;
    wait_done(cyc);
    total++;
    if (cyc + 1 !== 5) begin
      bad++; $display("FAIL shift_ignore_latency got=%0d want=5", cyc + 1);
    end
    total++;
    if (res !== {32'd100, 32'd56, 5'd3, 4'b0000}) begin
      bad++; $display("FAIL shift_ignore_result got=%h want=%h", res, {32'd100, 32'd56, 5'd3, 4'b0000});
    end
  endtask

  task automatic test_back_to_back;
    go(0, 100, 7);
    wait_done(cyc);
    start = 1; a = 1234; b = 0;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    total++;
    if ({done, ready, shifted_b, shamt, abs_a} !== {1'b0, 1'b0, 32'd0, 5'd0, 32'd1234}) begin
      bad++; $display("FAIL b2b_clear got=%h want=%h", {done, ready, shifted_b, shamt, abs_a},
                      {1'b0, 1'b0, 32'd0, 5'd0, 32'd1234});
    end
    wait_done(cyc);
    total++;
    if (cyc + 1 !== 2 || div_zero !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=cyc%0d/dz%b want=cyc2/dz1", cyc + 1, div_zero);
    end
  endtask

  task automatic test_mid_reset;
    int pulses = 0;
    go(0, 32'hFFFF_FFFF, 1);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({ready, done, res} !== {1'b1, 1'b0, 73'd0}) begin
      bad++; $display("FAIL mid_reset got=%h want=%h", {ready, done, res}, {1'b1, 1'b0, 73'd0});
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL mid_reset_pulse got=%0d want=0", pulses);
    end
    run("after_reset", 0, 100, 7, 5, {32'd100, 32'd56, 5'd3, 4'b0000});
  endtask

  initial begin
    test_reset();
    run("unsigned", 0, 100, 7, 5, {32'd100, 32'd56, 5'd3, 4'b0000});
    test_hold();
    run("signed", 1, 32'hFFFF_FF9C, 7, 5, {32'd100, 32'd56, 5'd3, 4'b0011});
    run("div_zero", 0, 1234, 0, 2, {32'd1234, 32'd0, 5'd0, 4'b1000});
    run("a_lt_b", 0, 5, 9, 2, {32'd5, 32'd9, 5'd0, 4'b0100});
    run("a_eq_b", 0, 7, 7, 2, {32'd7, 32'd7, 5'd0, 4'b0000});
    run("max_unsigned", 0, 32'hFFFF_FFFF, 1, 33, {32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 4'b0000});
    run("most_negative", 1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
        {32'h8000_0000, 32'h8000_0000, 5'd31, 4'b0001});
    test_start_in_shift();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
